// File: rtl/systolic_feeder_pkg.sv
// Shared definitions for the systolic array feeder: default array geometry
// and the controller state encoding.
package systolic_feeder_pkg;

  localparam int N_DEF         = 4;
  localparam int BIT_WIDTH_DEF = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COLLECT = 3'd1,
    PUSH    = 3'd2,
    STREAM  = 3'd3,
    DRAIN   = 3'd4
  } state_t;

endpackage

// File: rtl/systolic_feeder_skew_line.sv
// Fixed-depth delay line for one array row. Data and valid travel together
// so a row's valid always lines up with its data on the far end.
module skew_line #(
  parameter int depth     = 1,
  parameter int bit_width = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [bit_width-1:0] data,
  input  logic                 vld,
  output logic [bit_width-1:0] data_dly,
  output logic                 vld_dly
);

  logic [bit_width-1:0] data_sr [depth];
  logic [depth-1:0]     vld_sr;

  // Shift data and valid one stage per clock; reset empties the whole line.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < depth; i++) data_sr[i] <= '0;
      vld_sr <= '0;
    end else begin
      data_sr[0] <= data;
      vld_sr[0]  <= vld;
      for (int i = 1; i < depth; i++) begin
        data_sr[i] <= data_sr[i-1];
        vld_sr[i]  <= vld_sr[i-1];
      end
    end
  end

  assign data_dly = data_sr[depth-1];
  assign vld_dly  = vld_sr[depth-1];

endmodule

// File: rtl/systolic_feeder.sv
// Feeder for an N x N weight-stationary systolic array. A job collects N
// weight rows, pushes them down the columns with ctrl high, streams num_vec
// activation vectors through a per-row skew, then drains the array.
module systolic_feeder
  import systolic_feeder_pkg::*;
#(
  parameter int N         = N_DEF,
  parameter int bit_width = BIT_WIDTH_DEF,
  parameter int cnt_width = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [cnt_width-1:0]   num_vec,
  input  logic [N*bit_width-1:0] wt_row,
  input  logic                   wt_valid,
  output logic                   wt_ready,
  input  logic [N*bit_width-1:0] act_vec,
  input  logic                   act_valid,
  output logic                   act_ready,
  output logic                   ctrl,
  output logic [N*bit_width-1:0] wt_out,
  output logic [N*bit_width-1:0] data_out,
  output logic [N-1:0]           data_vld_out,
  output logic                   busy,
  output logic                   done
);

  // The step counter is shared by COLLECT, PUSH (0..N-1) and DRAIN (0..2N-2).
  localparam int IDX_W  = (N > 1) ? $clog2(N) : 1;
  localparam int STEP_W = $clog2(2 * N);
  localparam logic [STEP_W-1:0] LAST_BEAT  = STEP_W'(N - 1);
  localparam logic [STEP_W-1:0] LAST_DRAIN = STEP_W'(2 * N - 2);

  state_t                 state;
  logic [STEP_W-1:0]      step;
  logic [cnt_width-1:0]   vec_cnt;
  logic [cnt_width-1:0]   num_lat;
  logic [N*bit_width-1:0] wbuf [N];
  logic [N*bit_width-1:0] feed_data;
  logic                   feed_vld;

  // Job controller: sequences collect/push/stream/drain and owns all counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      step    <= '0;
      vec_cnt <= '0;
      num_lat <= '0;
      for (int i = 0; i < N; i++) wbuf[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            num_lat <= num_vec;
            step    <= '0;
            state   <= COLLECT;
          end
        end
        COLLECT: begin
          if (wt_valid) begin
            wbuf[step[IDX_W-1:0]] <= wt_row;
            if (step == LAST_BEAT) begin
              step  <= '0;
              state <= PUSH;
            end else begin
              step <= step + 1'b1;
            end
          end
        end
        PUSH: begin
          if (step == LAST_BEAT) begin
            step <= '0;
            if (num_lat != '0) begin
              vec_cnt <= '0;
              state   <= STREAM;
            end else begin
              state <= DRAIN;
            end
          end else begin
            step <= step + 1'b1;
          end
        end
        STREAM: begin
          if (act_valid) begin
            if (vec_cnt == num_lat - cnt_width'(1)) begin
              step  <= '0;
              state <= DRAIN;
            end else begin
              vec_cnt <= vec_cnt + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (step == LAST_DRAIN) begin
            step  <= '0;
            state <= IDLE;
          end else begin
            step <= step + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Status and handshake outputs are pure decodes of the registered state.
  assign busy      = (state != IDLE);
  assign wt_ready  = (state == COLLECT);
  assign act_ready = (state == STREAM);
  assign ctrl      = (state == PUSH);
  assign wt_out    = ctrl ? wbuf[step[IDX_W-1:0]] : '0;
  assign done      = (state == DRAIN) && (step == LAST_DRAIN);

  // Outside an accepted stream beat the skew lines are fed zero bubbles.
  assign feed_vld  = (state == STREAM) && act_valid;
  assign feed_data = feed_vld ? act_vec : '0;

  for (genvar r = 0; r < N; r++) begin : g_row
    skew_line #(
      .depth    (r + 1),
      .bit_width(bit_width)
    ) u_skew (
      .clk     (clk),
      .rst     (rst),
      .data    (feed_data[r*bit_width +: bit_width]),
      .vld     (feed_vld),
      .data_dly(data_out[r*bit_width +: bit_width]),
      .vld_dly (data_vld_out[r])
    );
  end

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder: weight load, stalled collect, skew,
// bubbles, empty job and reset abandoning a running job.
module tb_systolic_feeder;

  localparam int N    = 4;
  localparam int BW   = 8;
  localparam int CW   = 16;
  localparam int HIST = 300;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [CW-1:0]   num_vec;
  logic [N*BW-1:0] wt_row;
  logic            wt_valid;
  logic            wt_ready;
  logic [N*BW-1:0] act_vec;
  logic            act_valid;
  logic            act_ready;
  logic            ctrl;
  logic [N*BW-1:0] wt_out;
  logic [N*BW-1:0] data_out;
  logic [N-1:0]    data_vld_out;
  logic            busy;
  logic            done;

  int checks = 0;
  int passed = 0;

  logic [31:0] wt_rows [4];
  bit          wt_pat [$];
  bit          act_pat [$];
  logic [31:0] act_vals [$];
  int          acc_cycle [$];
  logic [31:0] pushed [$];
  logic [31:0] pe_w [4];

  logic [31:0] data_hist [HIST];
  logic [3:0]  vld_hist  [HIST];
  logic        busy_hist [HIST];
  logic        ctrl_hist [HIST];

  int ctrl_cycles, first_ctrl, last_ctrl, done_count, done_cycle;
  int act_ready_cycles, end_t;

  systolic_feeder #(.N(N), .bit_width(BW), .cnt_width(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .num_vec     (num_vec),
    .wt_row      (wt_row),
    .wt_valid    (wt_valid),
    .wt_ready    (wt_ready),
    .act_vec     (act_vec),
    .act_valid   (act_valid),
    .act_ready   (act_ready),
    .ctrl        (ctrl),
    .wt_out      (wt_out),
    .data_out    (data_out),
    .data_vld_out(data_vld_out),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Expected {valid, byte} on row r at cycle c given the accepted beats.
  function automatic logic [8:0] exp_row(input int c, input int r);
    logic [31:0] v;
    exp_row = '0;
    for (int i = 0; i < acc_cycle.size(); i++) begin
      if (acc_cycle[i] + r + 1 == c) begin
        v = act_vals[i];
        exp_row = {1'b1, v[r*8 +: 8]};
      end
    end
  endfunction

  // Runs one job, recording outputs per cycle; t=0 is the first cycle after start.
  task automatic run_job(input int n, input int rst_at);
    int t, wi, ai, k, a, stop_at;
    for (int i = 0; i < HIST; i++) begin
      data_hist[i] = '0; vld_hist[i] = '0; busy_hist[i] = 1'b0; ctrl_hist[i] = 1'b0;
    end
    for (int i = 0; i < 4; i++) pe_w[i] = '0;
    acc_cycle.delete();
    pushed.delete();
    ctrl_cycles = 0; first_ctrl = -1; last_ctrl = -1;
    done_count = 0; done_cycle = -1; act_ready_cycles = 0;
    start = 1'b1; num_vec = CW'(n);
    tick;
    start = 1'b0;
    t = 0; wi = 0; ai = 0; k = 0; a = 0; stop_at = 250;
    while (t < stop_at && t < HIST) begin
      data_hist[t] = data_out;
      vld_hist[t]  = data_vld_out;
      busy_hist[t] = busy;
      ctrl_hist[t] = ctrl;
      if (act_ready) act_ready_cycles++;
      if (ctrl) begin
        pushed.push_back(wt_out);
        pe_w[3] = pe_w[2]; pe_w[2] = pe_w[1]; pe_w[1] = pe_w[0]; pe_w[0] = wt_out;
        ctrl_cycles++;
        if (first_ctrl < 0) first_ctrl = t;
        last_ctrl = t;
      end
      if (done) begin
        done_count++;
        if (done_cycle < 0) begin
          done_cycle = t;
          stop_at = t + 4;
        end
      end
      wt_valid = 1'b0; act_valid = 1'b0; rst = 1'b0;
      wt_row = 32'hDEADBEEF; act_vec = 32'hA5A5A5A5;
      if (t == rst_at) begin
        rst = 1'b1;
        stop_at = t + 12;
      end else begin
        if (wt_ready) begin
          wt_valid = (wi < wt_pat.size()) ? wt_pat[wi] : 1'b1;
          wi++;
          if (wt_valid && k < 4) begin
            wt_row = wt_rows[k];
            k++;
          end
        end
        if (act_ready) begin
          act_valid = (ai < act_pat.size()) ? act_pat[ai] : 1'b1;
          ai++;
          if (act_valid) begin
            act_vec = (a < act_vals.size()) ? act_vals[a] : 32'h0;
            acc_cycle.push_back(t);
            a++;
          end
        end
      end
      tick;
      t++;
    end
    wt_valid = 1'b0; act_valid = 1'b0; rst = 1'b0;
    end_t = t;
    if (rst_at < 0) begin
      checks++;
      if (done_cycle < 0) $display("[TB] FAIL job_timeout: no done within %0d cycles, expected done", t);
      else passed++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; num_vec = '0;
    wt_row = '0; wt_valid = 1'b0; act_vec = '0; act_valid = 1'b0;
    tick; tick;
    rst = 1'b0;
    checks++;
    if ({busy, done, ctrl, wt_ready, act_ready} !== 5'b0)
      $display("[TB] FAIL reset_flags: got %b expected 00000", {busy, done, ctrl, wt_ready, act_ready});
    else passed++;
    checks++;
    if (wt_out !== 32'h0) $display("[TB] FAIL reset_wt_out: got %h expected 0", wt_out);
    else passed++;
    checks++;
    if (data_out !== 32'h0) $display("[TB] FAIL reset_data_out: got %h expected 0", data_out);
    else passed++;
    checks++;
    if (data_vld_out !== 4'h0) $display("[TB] FAIL reset_vld: got %h expected 0", data_vld_out);
    else passed++;
  endtask

  task automatic test_weight_load;
    logic [7:0]  b;
    logic [31:0] e;
    wt_rows = '{32'h04040404, 32'h03030303, 32'h02020202, 32'h01010101};
    wt_pat.delete(); act_pat.delete(); act_vals.delete();
    run_job(0, -1);
    checks++;
    if (ctrl_cycles !== 4) $display("[TB] FAIL wl_ctrl_cycles: got %0d expected 4", ctrl_cycles);
    else passed++;
    checks++;
    if (first_ctrl !== 4 || last_ctrl !== 7)
      $display("[TB] FAIL wl_ctrl_window: got %0d..%0d expected 4..7", first_ctrl, last_ctrl);
    else passed++;
    for (int r = 0; r < 4; r++) begin
      b = 8'(r + 1);
      e = {b, b, b, b};
      checks++;
      if (pe_w[r] !== e) $display("[TB] FAIL wl_pe_row%0d: got %h expected %h", r, pe_w[r], e);
      else passed++;
    end
  endtask

  task automatic test_stalled_collect;
    wt_rows = '{32'h11223344, 32'h55667788, 32'h99AABBCC, 32'hDDEEFF00};
    wt_pat = '{1, 0, 0, 1, 1, 0, 1};
    act_pat.delete(); act_vals = '{32'h01020304};
    run_job(1, -1);
    checks++;
    if (ctrl_cycles !== 4 || first_ctrl !== 7 || last_ctrl !== 10)
      $display("[TB] FAIL stall_push: got %0d cycles at %0d..%0d expected 4 at 7..10",
               ctrl_cycles, first_ctrl, last_ctrl);
    else passed++;
    for (int j = 0; j < 4; j++) begin
      checks++;
      if (j >= pushed.size() || pushed[j] !== wt_rows[j])
        $display("[TB] FAIL stall_order%0d: got %h expected %h", j,
                 (j < pushed.size()) ? pushed[j] : 32'hX, wt_rows[j]);
      else passed++;
    end
    checks++;
    if (pe_w[0] !== 32'hDDEEFF00 || pe_w[3] !== 32'h11223344)
      $display("[TB] FAIL stall_pe: got row0 %h row3 %h expected DDEEFF00 11223344", pe_w[0], pe_w[3]);
    else passed++;
    wt_pat.delete();
  endtask

  task automatic test_skew;
    logic [31:0] d;
    act_pat.delete(); act_vals = '{32'h04030201};
    run_job(1, -1);
    checks++;
    if (acc_cycle.size() !== 1 || acc_cycle[0] !== 8)
      $display("[TB] FAIL skew_accept: got %0d beats expected 1 at cycle 8", acc_cycle.size());
    else passed++;
    for (int r = 0; r < 4; r++) begin
      int cnt;
      d = data_hist[9 + r];
      checks++;
      if (d[r*8 +: 8] !== 8'(r + 1) || vld_hist[9 + r][r] !== 1'b1)
        $display("[TB] FAIL skew_row%0d: got %h/%b expected %h/1", r, d[r*8 +: 8], vld_hist[9 + r][r], 8'(r + 1));
      else passed++;
      cnt = 0;
      for (int c = 0; c < end_t; c++) if (vld_hist[c][r]) cnt++;
      checks++;
      if (cnt !== 1) $display("[TB] FAIL skew_vld_count%0d: got %0d expected 1", r, cnt);
      else passed++;
    end
    checks++;
    if (done_count !== 1 || done_cycle !== 15)
      $display("[TB] FAIL skew_done: got %0d pulses at %0d expected 1 at 15", done_count, done_cycle);
    else passed++;
  endtask

  task automatic test_bubbles;
    logic [8:0]  e;
    logic [31:0] d;
    act_pat  = '{1, 0, 0, 1, 0, 0, 1};
    act_vals = '{32'h0A0B0C0D, 32'h11121314, 32'hF0E0D0C0};
    run_job(3, -1);
    for (int r = 0; r < 4; r++) begin
      bit bad;
      int cnt;
      bad = 1'b0; cnt = 0;
      for (int c = 0; c < end_t; c++) begin
        e = exp_row(c, r);
        d = data_hist[c];
        if (vld_hist[c][r]) cnt++;
        if (!bad && ({vld_hist[c][r], d[r*8 +: 8]} !== e)) begin
          bad = 1'b1;
          $display("[TB] FAIL bubble_row%0d: cycle %0d got %b/%h expected %b/%h",
                   r, c, vld_hist[c][r], d[r*8 +: 8], e[8], e[7:0]);
        end
      end
      checks++;
      if (!bad) passed++;
      checks++;
      if (cnt !== 3) $display("[TB] FAIL bubble_count%0d: got %0d expected 3", r, cnt);
      else passed++;
    end
    checks++;
    if (done_count !== 1 || done_cycle !== 21)
      $display("[TB] FAIL bubble_done: got %0d pulses at %0d expected 1 at 21", done_count, done_cycle);
    else passed++;
    act_pat.delete();
  endtask

  task automatic test_zero_vec;
    act_pat.delete(); act_vals.delete();
    run_job(0, -1);
    checks++;
    if (act_ready_cycles !== 0) $display("[TB] FAIL zero_act_ready: got %0d cycles expected 0", act_ready_cycles);
    else passed++;
    checks++;
    if (last_ctrl !== 7 || done_cycle - last_ctrl !== 7)
      $display("[TB] FAIL zero_drain: push end %0d done %0d expected 7 and 14", last_ctrl, done_cycle);
    else passed++;
    checks++;
    if (done_count !== 1) $display("[TB] FAIL zero_done_count: got %0d expected 1", done_count);
    else passed++;
    checks++;
    if (((done_cycle >= 0) ? busy_hist[done_cycle + 1] : 1'b1) !== 1'b0)
      $display("[TB] FAIL zero_idle_after: busy still high after done, expected 0");
    else passed++;
  endtask

  task automatic test_reset_mid_job;
    logic [8:0]  e;
    logic [31:0] d;
    bit          bad;
    wt_rows  = '{32'h04040404, 32'h03030303, 32'h02020202, 32'h01010101};
    act_pat  = '{1, 0, 0, 0, 0, 0};
    act_vals = '{32'h44332211, 32'h88776655, 32'hCCBBAA99};
    run_job(3, 10);
    checks++;
    if (busy_hist[11] !== 1'b0 || ctrl_hist[11] !== 1'b0)
      $display("[TB] FAIL rst_mid_flags: got busy %b ctrl %b expected 0 0", busy_hist[11], ctrl_hist[11]);
    else passed++;
    checks++;
    if (data_hist[11] !== 32'h0 || vld_hist[11] !== 4'h0)
      $display("[TB] FAIL rst_mid_data: got %h/%h expected 0/0", data_hist[11], vld_hist[11]);
    else passed++;
    checks++;
    if (done_count !== 0) $display("[TB] FAIL rst_mid_no_done: got %0d pulses expected 0", done_count);
    else passed++;
    act_pat.delete();
    act_vals = '{32'h0F0E0D0C, 32'h1B2B3B4B};
    run_job(2, -1);
    bad = 1'b0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < end_t; c++) begin
        e = exp_row(c, r);
        d = data_hist[c];
        if (!bad && ({vld_hist[c][r], d[r*8 +: 8]} !== e)) begin
          bad = 1'b1;
          $display("[TB] FAIL rst_rerun_row%0d: cycle %0d got %b/%h expected %b/%h",
                   r, c, vld_hist[c][r], d[r*8 +: 8], e[8], e[7:0]);
        end
      end
    end
    checks++;
    if (!bad) passed++;
    checks++;
    if (done_count !== 1 || done_cycle !== 16 || pe_w[3] !== 32'h04040404)
      $display("[TB] FAIL rst_rerun_done: got %0d pulses at %0d pe3 %h expected 1 at 16 pe3 04040404",
               done_count, done_cycle, pe_w[3]);
    else passed++;
  endtask

  initial begin
    $display("[TB] systolic_feeder bench start");
    test_reset();
    test_weight_load();
    test_stalled_collect();
    test_skew();
    test_bubbles();
    test_zero_vec();
    test_reset_mid_job();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/systolic_feeder.md
SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

Interface
REQ-001 Parameters SHALL be: N, default 4, array dimension (rows = columns); bit_width, default 8, weight/activation width; cnt_width, default 16, vector-count width.
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
  clk  input  1  single clock; all logic on posedge.
  rst  input  1  synchronous, active-high reset.
  start  input  1  one-cycle pulse; begins a job when idle.
  num_vec  input  cnt_width  activation vectors in the job; sampled on accepted start.
  wt_row  input  N*bit_width  one weight row; column c in bits [c*bit_width +: bit_width].
  wt_valid  input  1  wt_row valid.
  wt_ready  output  1  feeder accepts wt_row this cycle.
  act_vec  input  N*bit_width  one activation vector; row r in bits [r*bit_width +: bit_width].
  act_valid  input  1  act_vec valid.
  act_ready  output  1  feeder accepts act_vec this cycle.
  ctrl  output  1  array weight-load control, broadcast to all PEs.
  wt_out  output  N*bit_width  per-column weight path into the top PE row.
  data_out  output  N*bit_width  per-row activations into the left PE column, skewed.
  data_vld_out  output  N  per-row valid, skewed identically to data_out.
  busy  output  1  high in every state except IDLE.
  done  output  1  one-cycle pulse on job completion.

Function
REQ-003 The FSM SHALL have states IDLE, COLLECT, PUSH, STREAM, DRAIN.
REQ-004 IDLE: start=1 SHALL latch num_vec and go to COLLECT; start in any other state SHALL be ignored.
REQ-005 COLLECT: wt_ready=1; each wt_valid&&wt_ready beat SHALL store wt_row into the weight buffer at index k = 0..N-1 in arrival order; after beat N-1, go to PUSH.
REQ-006 Weight rows SHALL arrive bottom row first: beat k holds the weights for PE row N-1-k.
REQ-007 PUSH SHALL last exactly N consecutive cycles without stall: cycle j drives wt_out = buffer[j] and ctrl=1; on the cycle after PUSH, ctrl=0.
REQ-008 After PUSH, go to STREAM if the latched num_vec > 0; otherwise go to DRAIN.
REQ-009 STREAM: act_ready=1; each accepted beat SHALL enter the skew stage with valid=1; a cycle without a beat SHALL enter zeros with valid=0 (bubble); after accepted beat num_vec, go to DRAIN.
REQ-010 Skew: row r of data_out/data_vld_out SHALL equal the value entered r+1 cycles earlier (row 0 latency 1, row N-1 latency N).
REQ-011 DRAIN SHALL last exactly 2N-1 cycles, entering zeros with valid=0; on its last cycle done=1, then go to IDLE.
REQ-012 Outside PUSH, ctrl=0 and wt_out=0; outside COLLECT, wt_ready=0; outside STREAM, act_ready=0.
REQ-013 Counters SHALL be wide enough for num_vec = 2^cnt_width-1 with no wrap; the vector counter SHALL clear on entry to STREAM.
REQ-014 Activation and weight values SHALL pass through bit-exact; no arithmetic on data.

Reset
REQ-015 rst=1 at any clock edge, including mid-job, SHALL force IDLE; clear the weight buffer, all skew registers, and all counters; and drive every output to 0 on the following cycle.
REQ-016 A job in progress when reset is applied SHALL be abandoned; done SHALL NOT pulse for it.

Structure
REQ-017 The FSM state encoding, and N / bit_width defaults, SHALL live in a shared package used by the array top.
REQ-018 Skewing SHALL use one sub-module, skew_line, instantiated per row r with depth r+1, carrying data and valid together.

Verification
REQ-019 Weight load: rows 0x04040404, 0x03030303, 0x02020202, 0x01010101 with no stall -> ctrl high for exactly 4 cycles; a 4x4 MAC array then holds weight 1 in row 0 through weight 4 in row 3.
REQ-020 Stalled COLLECT: wt_valid toggling 1,0,0,1,1,0,1 -> PUSH still 4 contiguous cycles with ctrl=1 and correct order.
REQ-021 Skew: num_vec=1, act_vec bytes {4,3,2,1} -> data_out row r = r+1 exactly at cycle r+1 after acceptance; valid asserted one cycle per row.
REQ-022 Bubbles: num_vec=3, act_valid low for 2 cycles between beats -> 3 valid vectors per row, zeros/valid=0 in bubble slots, done once.
REQ-023 num_vec=0 -> PUSH, then DRAIN of 7 cycles, done pulse, no act_ready.
REQ-024 rst asserted during STREAM -> next cycle busy=0, data_out=0, ctrl=0; no done; a new start then runs a full job correctly.
